// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT frame sequencer: state encoding,
// config-word width and config-word packing.
package fft_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        ALIGN,
        STREAM,
        WAIT_OUT
    } state_t;

    // Config word is {zero pad, scale, fwd_inv}, padded up to whole bytes.
    function automatic int cfg_width(input int scale_w);
        return 8 * ((scale_w + 8) / 8);
    endfunction

    function automatic logic [63:0] pack_cfg(input logic [31:0] scale,
                                             input int          scale_w,
                                             input logic        fwd_inv);
        logic [63:0] mask;
        mask = (64'd1 << scale_w) - 64'd1;
        return (({32'd0, scale} & mask) << 1) | {63'd0, fwd_inv};
    endfunction

endpackage

// File: rtl/fft_frame_counter.sv
// Modulo-NPOINT sample index for one FFT frame; flags the final sample
// and can be forced back to zero.
module fft_frame_counter #(
    parameter int NPOINT = 1024
) (
    input  logic sys_clk,
    input  logic sys_rstn,
    input  logic clear,
    input  logic advance,
    output logic last
);

    localparam int IDX_W = (NPOINT > 1) ? $clog2(NPOINT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOINT - 1);

    logic [IDX_W-1:0] idx;

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (advance) begin
            idx <= last ? '0 : idx + IDX_W'(1);
        end
    end

    assign last = (idx == LAST_IDX);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer between the ADC stream adapter and the FFT core: configures
// the core, aligns to the adapter frame boundary and forwards NPOINT samples per frame.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter  int NPOINT  = 1024,
    parameter  int DIN_W   = 16,
    parameter  int SCALE_W = 10,
    parameter  int CNT_W   = 16,
    localparam int CFG_W   = cfg_width(SCALE_W)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     nframes,
    input  logic                 cfg_fwd_inv,
    input  logic [SCALE_W-1:0]   cfg_scale,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    input  logic                 in_tlast,
    input  logic [2*DIN_W-1:0]   in_tdata,
    output logic                 fft_s_tvalid,
    input  logic                 fft_s_tready,
    output logic                 fft_s_tlast,
    output logic [2*DIN_W-1:0]   fft_s_tdata,
    output logic                 fft_cfg_tvalid,
    input  logic                 fft_cfg_tready,
    output logic [CFG_W-1:0]     fft_cfg_tdata,
    input  logic                 fft_out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err_align,
    output logic [CNT_W-1:0]     frames_done
);

    state_t state;
    state_t state_nxt;

    logic               go_idle;
    logic [CNT_W-1:0]   nframes_r;
    logic [CNT_W-1:0]   frames_done_r;
    logic [CNT_W-1:0]   frames_done_inc;
    logic [SCALE_W-1:0] scale_r;
    logic               fwd_r;
    logic               err_align_r;
    logic               frame_err_r;
    logic               abort_pend_r;
    logic               done_r;
    logic               cnt_last;
    logic               beat_hs;
    logic               abort_now;
    logic               run_over;

    assign beat_hs         = (state == STREAM) && in_tvalid && fft_s_tready;
    assign abort_now       = abort_pend_r || abort;
    assign frames_done_inc = frames_done_r + CNT_W'(1);
    assign run_over        = abort_now || ((nframes_r != '0) && (frames_done_inc == nframes_r));

    fft_frame_counter #(
        .NPOINT (NPOINT)
    ) u_frame_counter (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .clear    (state != STREAM),
        .advance  (beat_hs),
        .last     (cnt_last)
    );

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outside STREAM the adapter is always drained so stale samples never back up.
    always_comb begin
        state_nxt      = state;
        go_idle        = 1'b0;
        in_tready      = 1'b1;
        fft_s_tvalid   = 1'b0;
        fft_s_tlast    = 1'b0;
        fft_s_tdata    = '0;
        fft_cfg_tvalid = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CONFIG;
                end
            end
            CONFIG: begin
                fft_cfg_tvalid = 1'b1;
                if (fft_cfg_tready) begin
                    if (abort_now) begin
                        state_nxt = IDLE;
                        go_idle   = 1'b1;
                    end else begin
                        state_nxt = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (abort_now) begin
                    state_nxt = IDLE;
                    go_idle   = 1'b1;
                end else if (in_tvalid && in_tlast) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                in_tready    = fft_s_tready;
                fft_s_tvalid = in_tvalid;
                fft_s_tdata  = in_tdata;
                fft_s_tlast  = cnt_last;
                if (beat_hs && cnt_last) begin
                    state_nxt = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (fft_out_last) begin
                    if (run_over) begin
                        state_nxt = IDLE;
                        go_idle   = 1'b1;
                    end else if (frame_err_r) begin
                        state_nxt = ALIGN;
                    end else begin
                        state_nxt = CONFIG;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A misaligned frame is remembered separately from the sticky flag so the
    // next frame re-aligns without reconfiguring the core.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            nframes_r     <= '0;
            scale_r       <= '0;
            fwd_r         <= 1'b0;
            frames_done_r <= '0;
            err_align_r   <= 1'b0;
            frame_err_r   <= 1'b0;
            abort_pend_r  <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r <= go_idle;
            if ((state == IDLE) && start) begin
                nframes_r     <= nframes;
                scale_r       <= cfg_scale;
                fwd_r         <= cfg_fwd_inv;
                frames_done_r <= '0;
                err_align_r   <= 1'b0;
                frame_err_r   <= 1'b0;
                abort_pend_r  <= 1'b0;
            end else begin
                if (busy && abort) begin
                    abort_pend_r <= 1'b1;
                end
                if (go_idle) begin
                    abort_pend_r <= 1'b0;
                end
                if (beat_hs && (in_tlast != cnt_last)) begin
                    err_align_r <= 1'b1;
                    frame_err_r <= 1'b1;
                end
                if ((state == WAIT_OUT) && fft_out_last) begin
                    frames_done_r <= frames_done_inc;
                    frame_err_r   <= 1'b0;
                end
            end
        end
    end

    assign busy          = (state != IDLE);
    assign done          = done_r;
    assign err_align     = err_align_r;
    assign frames_done   = frames_done_r;
    assign fft_cfg_tdata = CFG_W'(pack_cfg(32'(scale_r), SCALE_W, fwd_r));

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized scoreboard bench for fft_frame_ctrl: the driver pushes expected
// config words, forwarded beats and run completions; a monitor pops and compares.
`timescale 1ns/1ps
module tb_fft_frame_ctrl;

    localparam int NPOINT  = 16;
    localparam int DIN_W   = 16;
    localparam int SCALE_W = 10;
    localparam int CNT_W   = 16;
    localparam int CFG_W   = 16;

    logic                 sys_clk;
    logic                 sys_rstn;
    logic                 start;
    logic                 abort;
    logic [CNT_W-1:0]     nframes;
    logic                 cfg_fwd_inv;
    logic [SCALE_W-1:0]   cfg_scale;
    logic                 in_tvalid;
    logic                 in_tready;
    logic                 in_tlast;
    logic [2*DIN_W-1:0]   in_tdata;
    logic                 fft_s_tvalid;
    logic                 fft_s_tready;
    logic                 fft_s_tlast;
    logic [2*DIN_W-1:0]   fft_s_tdata;
    logic                 fft_cfg_tvalid;
    logic                 fft_cfg_tready;
    logic [CFG_W-1:0]     fft_cfg_tdata;
    logic                 fft_out_last;
    logic                 busy;
    logic                 done;
    logic                 err_align;
    logic [CNT_W-1:0]     frames_done;

    fft_frame_ctrl #(
        .NPOINT  (NPOINT),
        .DIN_W   (DIN_W),
        .SCALE_W (SCALE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rstn       (sys_rstn),
        .start          (start),
        .abort          (abort),
        .nframes        (nframes),
        .cfg_fwd_inv    (cfg_fwd_inv),
        .cfg_scale      (cfg_scale),
        .in_tvalid      (in_tvalid),
        .in_tready      (in_tready),
        .in_tlast       (in_tlast),
        .in_tdata       (in_tdata),
        .fft_s_tvalid   (fft_s_tvalid),
        .fft_s_tready   (fft_s_tready),
        .fft_s_tlast    (fft_s_tlast),
        .fft_s_tdata    (fft_s_tdata),
        .fft_cfg_tvalid (fft_cfg_tvalid),
        .fft_cfg_tready (fft_cfg_tready),
        .fft_cfg_tdata  (fft_cfg_tdata),
        .fft_out_last   (fft_out_last),
        .busy           (busy),
        .done           (done),
        .err_align      (err_align),
        .frames_done    (frames_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [2*DIN_W-1:0] data;
        logic               last;
    } beat_t;

    beat_t            exp_fft[$];
    logic [CFG_W-1:0] exp_cfg[$];
    logic [CNT_W-1:0] exp_done[$];

    int checks        = 0;
    int errors        = 0;
    int cfg_hs_count  = 0;
    int exp_cfg_total = 0;
    bit ready_random  = 1'b0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Downstream readiness; random when exercising backpressure.
    always @(negedge sys_clk) begin
        if (ready_random) begin
            fft_s_tready   = ($urandom_range(0, 3) != 0);
            fft_cfg_tready = 1'($urandom_range(0, 1));
        end else begin
            fft_s_tready   = 1'b1;
            fft_cfg_tready = 1'b1;
        end
    end

    // Monitor: samples just before each rising edge, when all inputs are settled.
    logic [2*DIN_W-1:0] prev_s_data;
    logic               prev_s_last;
    bit                 prev_s_stall = 1'b0;
    logic [CFG_W-1:0]   prev_c_data;
    bit                 prev_c_stall = 1'b0;

    always @(negedge sys_clk) begin
        beat_t e;
        #4;
        if (!sys_rstn) begin
            prev_s_stall = 1'b0;
            prev_c_stall = 1'b0;
        end else begin
            if (prev_s_stall) begin
                check_output("s_tvalid_held", fft_s_tvalid, 1);
                check_output("s_tdata_stable", fft_s_tdata, prev_s_data);
                check_output("s_tlast_stable", fft_s_tlast, prev_s_last);
            end
            if (fft_s_tvalid && fft_s_tready) begin
                if (exp_fft.size() == 0) begin
                    check_output("unexpected_fft_beat", fft_s_tdata, 64'hDEAD_0000_0000_0000);
                end else begin
                    e = exp_fft.pop_front();
                    check_output("s_tdata", fft_s_tdata, e.data);
                    check_output("s_tlast", fft_s_tlast, e.last);
                end
            end
            prev_s_stall = fft_s_tvalid && !fft_s_tready;
            prev_s_data  = fft_s_tdata;
            prev_s_last  = fft_s_tlast;

            if (prev_c_stall) begin
                check_output("cfg_tvalid_held", fft_cfg_tvalid, 1);
                check_output("cfg_tdata_stable", fft_cfg_tdata, prev_c_data);
            end
            if (fft_cfg_tvalid && fft_cfg_tready) begin
                cfg_hs_count++;
                if (exp_cfg.size() == 0) begin
                    check_output("unexpected_cfg_beat", fft_cfg_tdata, 64'hDEAD_0000_0000_0000);
                end else begin
                    check_output("cfg_tdata", fft_cfg_tdata, exp_cfg.pop_front());
                end
            end
            prev_c_stall = fft_cfg_tvalid && !fft_cfg_tready;
            prev_c_data  = fft_cfg_tdata;

            if (done) begin
                if (exp_done.size() == 0) begin
                    check_output("unexpected_done", frames_done, 64'hDEAD_0000_0000_0000);
                end else begin
                    check_output("done_frames_done", frames_done, exp_done.pop_front());
                end
            end
        end
    end

    task automatic send_beat(input logic [2*DIN_W-1:0] d, input logic l, input bit with_abort);
        int guard;
        bit hs;
        if ($urandom_range(0, 3) == 0) begin
            in_tvalid = 1'b0;
            @(negedge sys_clk);
        end
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tlast  = l;
        abort     = with_abort;
        guard     = 0;
        hs        = 1'b0;
        while (!hs && guard < 200) begin
            #4;
            hs = in_tready;
            @(negedge sys_clk);
            abort = 1'b0;
            guard++;
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        if (!hs) check_output("beat_accept_timeout", hs, 1);
    endtask

    task automatic wait_cfg(input int target);
        int guard = 0;
        while (cfg_hs_count < target && guard < 300) begin
            @(negedge sys_clk);
            guard++;
        end
        check_output("cfg_handshake_seen", (cfg_hs_count >= target), 1);
    endtask

    task automatic wait_drained();
        int guard = 0;
        while (exp_fft.size() != 0 && guard < 400) begin
            @(negedge sys_clk);
            guard++;
        end
        check_output("frame_drained", exp_fft.size(), 0);
    endtask

    task automatic assert_reset_and_check();
        in_tvalid = 1'b1;
        in_tdata  = $urandom;
        #2;
        sys_rstn = 1'b0;
        #1;
        check_output("rst_in_tready", in_tready, 1);
        check_output("rst_fft_s_tvalid", fft_s_tvalid, 0);
        check_output("rst_fft_s_tlast", fft_s_tlast, 0);
        check_output("rst_fft_s_tdata", fft_s_tdata, 0);
        check_output("rst_fft_cfg_tvalid", fft_cfg_tvalid, 0);
        check_output("rst_fft_cfg_tdata", fft_cfg_tdata, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_err_align", err_align, 0);
        check_output("rst_frames_done", frames_done, 0);
        exp_fft.delete();
        exp_cfg.delete();
        exp_done.delete();
        cfg_hs_count  = 0;
        exp_cfg_total = 0;
        in_tvalid     = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rstn = 1'b1;
        @(negedge sys_clk);
    endtask

    // One run: start with a snapshot, then per frame a discarded pre-roll ending
    // in tlast followed by NPOINT forwarded beats and the FFT output-frame pulse.
    task automatic apply_stimulus(input logic [CNT_W-1:0] n, input logic [SCALE_W-1:0] sc,
                                  input logic fw, input int frames, input int abort_frame,
                                  input int misalign_frame, input int first_pos,
                                  input bit abort_with_start, input int reset_frame);
        logic [CFG_W-1:0]   cfgw;
        logic [2*DIN_W-1:0] d;
        bit                 need_cfg;
        bit                 any_mis;
        bit                 last_frame;
        int                 pre;
        cfgw        = CFG_W'({sc, fw});
        nframes     = n;
        cfg_scale   = sc;
        cfg_fwd_inv = fw;
        start       = 1'b1;
        abort       = abort_with_start;
        exp_cfg.push_back(cfgw);
        exp_cfg_total++;
        @(negedge sys_clk);
        start       = 1'b0;
        abort       = 1'b0;
        nframes     = CNT_W'($urandom);
        cfg_scale   = SCALE_W'($urandom);
        cfg_fwd_inv = 1'($urandom);
        check_output("busy_after_start", busy, 1);
        need_cfg = 1'b1;
        any_mis  = 1'b0;
        for (int f = 1; f <= frames; f++) begin
            if (need_cfg) wait_cfg(exp_cfg_total);
            pre = (f == 1 && first_pos >= 0) ? NPOINT - first_pos : $urandom_range(1, 4);
            for (int p = 0; p < pre; p++) send_beat($urandom, (p == pre - 1), 1'b0);
            for (int i = 0; i < NPOINT; i++) begin
                if (f == reset_frame && i == 5) begin
                    check_output("pre_reset_err_align", err_align, any_mis);
                    check_output("pre_reset_frames_done", frames_done, f - 1);
                    assert_reset_and_check();
                    return;
                end
                d = $urandom;
                exp_fft.push_back({d, (i == NPOINT - 1)});
                send_beat(d, (f == misalign_frame) ? (i == 9) : (i == NPOINT - 1),
                          (f == abort_frame) && (i == 7));
            end
            if (f == misalign_frame) any_mis = 1'b1;
            wait_drained();
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
            last_frame = (f == frames);
            if (last_frame) begin
                exp_done.push_back(CNT_W'(f));
            end else if (f != misalign_frame) begin
                exp_cfg.push_back(cfgw);
                exp_cfg_total++;
            end
            need_cfg     = (f != misalign_frame);
            fft_out_last = 1'b1;
            @(negedge sys_clk);
            fft_out_last = 1'b0;
            check_output("busy_after_out_last", busy, !last_frame);
            check_output("done_after_out_last", done, last_frame);
        end
        check_output("run_err_align", err_align, any_mis);
        check_output("run_frames_done", frames_done, frames);
        @(negedge sys_clk);
        check_output("done_one_cycle", done, 0);
        check_output("idle_after_run", busy, 0);
    endtask

    initial begin
        sys_rstn     = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        nframes      = '0;
        cfg_fwd_inv  = 1'b0;
        cfg_scale    = '0;
        in_tvalid    = 1'b0;
        in_tlast     = 1'b0;
        in_tdata     = '0;
        fft_out_last = 1'b0;
        #1;
        check_output("init_in_tready", in_tready, 1);
        check_output("init_busy", busy, 0);
        check_output("init_cfg_tvalid", fft_cfg_tvalid, 0);
        check_output("init_s_tvalid", fft_s_tvalid, 0);
        repeat (3) @(negedge sys_clk);
        sys_rstn = 1'b1;
        @(negedge sys_clk);
        check_output("idle_in_tready", in_tready, 1);
        check_output("idle_done", done, 0);
        check_output("idle_frames_done", frames_done, 0);

        // Abort while idle is ignored; stray fft_out_last too.
        abort        = 1'b1;
        fft_out_last = 1'b1;
        @(negedge sys_clk);
        abort        = 1'b0;
        fft_out_last = 1'b0;
        @(negedge sys_clk);
        check_output("idle_abort_ignored", busy, 0);
        check_output("idle_stray_out_last", frames_done, 0);

        $display("[TB] single frame");
        apply_stimulus(1, 10'h2AB, 1'b1, 1, 0, 0, -1, 1'b0, 0);

        $display("[TB] alignment from adapter beat 5");
        for (int p = 0; p < 5; p++) send_beat($urandom, 1'b0, 1'b0);
        apply_stimulus(1, SCALE_W'($urandom), 1'($urandom), 1, 0, 0, 5, 1'b0, 0);

        $display("[TB] backpressure, counted run of 3, start with abort");
        ready_random = 1'b1;
        apply_stimulus(3, SCALE_W'($urandom), 1'($urandom), 3, 0, 0, -1, 1'b1, 0);

        $display("[TB] continuous run aborted in frame 2");
        apply_stimulus(0, SCALE_W'($urandom), 1'($urandom), 2, 2, 0, -1, 1'b0, 0);

        $display("[TB] misaligned frame then realign");
        apply_stimulus(2, SCALE_W'($urandom), 1'($urandom), 2, 0, 1, -1, 1'b0, 0);

        $display("[TB] reset mid-stream");
        apply_stimulus(2, SCALE_W'($urandom), 1'($urandom), 2, 0, 1, -1, 1'b0, 2);

        $display("[TB] recovery after reset");
        apply_stimulus(1, SCALE_W'($urandom), 1'($urandom), 1, 0, 0, -1, 1'b0, 0);

        repeat (3) @(negedge sys_clk);
        check_output("left_fft_beats", exp_fft.size(), 0);
        check_output("left_cfg_beats", exp_cfg.size(), 0);
        check_output("left_done", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
